// File: rtl/srt_divide_iter.sv
// ---------------------------------------------------------------------------
// srt_divide_iter
//
// Purpose:
//   Iterative radix-2 SRT divider for unsigned normalised fractions 0.N / 0.D.
//   The divider retires one signed digit {-1, 0, +1} per cycle. It converts the
//   digits on the fly into the quotient, using the pair Q and QM = Q - ulp. A
//   correction cycle then fixes a negative final partial remainder.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request; sampled only while the FSM is in IDLE
//   N          dividend fraction 0.N
//   D          divisor fraction 0.D (MSB must be 1)
//   busy       high while a division is in flight
//   done       one-cycle pulse: quotient/remainder/err valid
//   err        operand error (D MSB clear or N >= D), valid with done
//   quotient   floor(N*2^WIDTH / D)
//   remainder  N*2^WIDTH - quotient*D, 0 <= remainder < D
//   w          current partial remainder, two's complement, format s i.f
//   q          last selected digit: 01=+1, 00=0, 11=-1 (00 outside ITER)
//   fsm_state  current FSM state (IDLE=0, ITER=1, CORR=2, FIN=3)
//
// Handshake: start is a request with no ready. It is taken only in IDLE, and
// taking it latches N and D and raises busy. While busy is high, start and
// operand changes are ignored. done pulses for one cycle with busy low, and
// the results then hold until the next accepted start. A start that is high
// during the done cycle is taken at the end of that cycle.
// ---------------------------------------------------------------------------
module srt_divide_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] N,
    input  logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [WIDTH+1:0] w,
    output logic [1:0]       q,
    output logic [1:0]       fsm_state
);

    localparam int WW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        CORR = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] qm_acc;
    logic [CW-1:0]    count;

    logic             op_bad;
    logic             last;
    logic [WW-1:0]    w2;
    logic [WW-1:0]    d_ext;
    logic signed [3:0] top;
    logic             sel_pos;
    logic             sel_neg;
    logic [WW-1:0]    w_nx;
    logic [WIDTH-1:0] corr_rem;

    assign fsm_state = state;

    assign op_bad = ~D[WIDTH-1] || (N >= D);
    assign last   = (count == CW'(WIDTH - 1));

    // |w| <= D < 1 keeps the top two bits of w equal, so the left shift
    // loses no information.
    assign w2    = {w[WW-2:0], 1'b0};
    assign d_ext = {2'b00, d_reg};

    // The top nibble of 2w is 2w truncated to quarters. With truncation
    // toward minus infinity, "t >= 2" is exactly 2w >= 1/2, and "t < -2" is
    // exactly 2w < -1/2.
    assign top     = w2[WW-1:WW-4];
    assign sel_pos = (top >= 4'sd2);
    assign sel_neg = (top < -4'sd2);

    always_comb begin
        w_nx = w2;
        if (sel_pos) begin
            w_nx = w2 - d_ext;
        end else if (sel_neg) begin
            w_nx = w2 + d_ext;
        end
    end

    // The low bits of w + D depend only on the low bits of the operands.
    assign corr_rem = w[WIDTH-1:0] + d_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = op_bad ? FIN : ITER;
            ITER:    if (last) state_nx = CORR;
            CORR:    state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            w         <= '0;
            q         <= 2'b00;
            d_reg     <= '0;
            q_acc     <= '0;
            qm_acc    <= '0;
            count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    q <= 2'b00;
                    if (start) begin
                        busy      <= 1'b1;
                        err       <= op_bad;
                        quotient  <= '0;
                        remainder <= '0;
                        d_reg     <= D;
                        q_acc     <= '0;
                        qm_acc    <= '0;
                        count     <= '0;
                        if (!op_bad) begin
                            w <= {2'b00, N};
                        end
                    end
                end
                ITER: begin
                    w     <= w_nx;
                    count <= count + 1'b1;
                    if (sel_pos) begin
                        q      <= 2'b01;
                        q_acc  <= {q_acc[WIDTH-2:0], 1'b1};
                        qm_acc <= {q_acc[WIDTH-2:0], 1'b0};
                    end else if (sel_neg) begin
                        q      <= 2'b11;
                        q_acc  <= {qm_acc[WIDTH-2:0], 1'b1};
                        qm_acc <= {qm_acc[WIDTH-2:0], 1'b0};
                    end else begin
                        q      <= 2'b00;
                        q_acc  <= {q_acc[WIDTH-2:0], 1'b0};
                        qm_acc <= {qm_acc[WIDTH-2:0], 1'b1};
                    end
                end
                CORR: begin
                    q <= 2'b00;
                    if (w[WW-1]) begin
                        quotient  <= qm_acc;
                        remainder <= corr_rem;
                    end else begin
                        quotient  <= q_acc;
                        remainder <= w[WIDTH-1:0];
                    end
                end
                FIN: begin
                    q    <= 2'b00;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: q <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_srt_divide_iter.sv
// ---------------------------------------------------------------------------
// tb_srt_divide_iter
//
// Directed bench for srt_divide_iter. It uses an 8-bit instance for the digit
// trace and the FSM scenarios. A 16-bit instance checks the identity
// N*2^16 = Q*D + R. Inputs are driven 1 time unit after the rising edge, and
// outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_srt_divide_iter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] N = '0;
    logic [7:0] D = '0;
    logic       busy, done, err;
    logic [7:0] quotient, remainder;
    logic [9:0] w;
    logic [1:0] q;
    logic [1:0] fsm_state;

    logic        start16 = 1'b0;
    logic [15:0] n16 = '0;
    logic [15:0] d16 = '0;
    logic        busy16, done16, err16;
    logic [15:0] quotient16, remainder16;
    logic [17:0] w16;
    logic [1:0]  q16;
    logic [1:0]  fsm_state16;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] q_log[0:63];
    logic [9:0] w_log[0:63];
    logic       busy_log[0:63];
    int         lat;

    srt_divide_iter #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .N(N), .D(D),
        .busy(busy), .done(done), .err(err), .quotient(quotient),
        .remainder(remainder), .w(w), .q(q), .fsm_state(fsm_state)
    );

    srt_divide_iter #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(reset), .start(start16), .N(n16), .D(d16),
        .busy(busy16), .done(done16), .err(err16), .quotient(quotient16),
        .remainder(remainder16), .w(w16), .q(q16), .fsm_state(fsm_state16)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issues one start pulse and logs q/w/busy after every edge. Index 1 is
    // the edge that samples start. The log stops at done or after 40 edges.
    task automatic run_div(input logic [7:0] n, input logic [7:0] d);
        N = n; D = d; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        q_log[1] = q; w_log[1] = w; busy_log[1] = busy;
        while (!done && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            q_log[lat] = q; w_log[lat] = w; busy_log[lat] = busy;
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({busy, done, err} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 000", {busy, done, err});
        end
        vectors++;
        if ({quotient, remainder} !== 16'h0000) begin
            miscompares++; $display("FAIL reset_results: got %h expected 0000", {quotient, remainder});
        end
        vectors++;
        if ({w, q, fsm_state} !== 14'h0) begin
            miscompares++; $display("FAIL reset_w_q_state: got %h expected 0", {w, q, fsm_state});
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_main_trace();
        logic [1:0] exp_q[8] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b11, 2'b00};
        logic [9:0] exp_w[8] = '{10'h079, 10'h02D, 10'h05A, 10'h3EF, 10'h3DE, 10'h3BC, 10'h03D, 10'h07A};
        run_div(8'h9F, 8'hC5);
        vectors++;
        if (lat !== 11) begin
            miscompares++; $display("FAIL main_latency: got edge %0d expected edge 11", lat);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (q_log[i+2] !== exp_q[i]) begin
                miscompares++; $display("FAIL main_digit%0d: got %b expected %b", i, q_log[i+2], exp_q[i]);
            end
            vectors++;
            if (w_log[i+2] !== exp_w[i]) begin
                miscompares++; $display("FAIL main_w%0d: got %h expected %h", i, w_log[i+2], exp_w[i]);
            end
        end
        for (int i = 1; i <= 10; i++) begin
            vectors++;
            if (busy_log[i] !== 1'b1) begin
                miscompares++; $display("FAIL main_busy_edge%0d: got %b expected 1", i, busy_log[i]);
            end
        end
        vectors++;
        if (q_log[10] !== 2'b00) begin
            miscompares++; $display("FAIL main_q_after_iter: got %b expected 00", q_log[10]);
        end
        vectors++;
        if ({busy, err, quotient, remainder} !== {1'b0, 1'b0, 8'hCE, 8'h7A}) begin
            miscompares++; $display("FAIL main_result: got busy=%b err=%b q=%h r=%h expected 0 0 ce 7a",
                                    busy, err, quotient, remainder);
        end
        @(posedge clock); #1;
        vectors++;
        if ({done, quotient, remainder} !== {1'b0, 8'hCE, 8'h7A}) begin
            miscompares++; $display("FAIL main_hold: got done=%b q=%h r=%h expected 0 ce 7a", done, quotient, remainder);
        end
    endtask

    task automatic test_zero_dividend();
        int nonzero_digits = 0;
        run_div(8'h00, 8'h80);
        for (int i = 1; i <= lat; i++) if (q_log[i] !== 2'b00) nonzero_digits++;
        vectors++;
        if (nonzero_digits !== 0) begin
            miscompares++; $display("FAIL zero_digits: got %0d nonzero digits expected 0", nonzero_digits);
        end
        vectors++;
        if ({lat[7:0], err, quotient, remainder} !== {8'd11, 1'b0, 8'h00, 8'h00}) begin
            miscompares++; $display("FAIL zero_result: got lat=%0d err=%b q=%h r=%h expected 11 0 00 00",
                                    lat, err, quotient, remainder);
        end
    endtask

    task automatic test_max_quotient();
        run_div(8'h7F, 8'h80);
        vectors++;
        if ({err, quotient, remainder} !== {1'b0, 8'hFE, 8'h00}) begin
            miscompares++; $display("FAIL max_result: got err=%b q=%h r=%h expected 0 fe 00", err, quotient, remainder);
        end
        vectors++;
        if (!(remainder < 8'h80)) begin
            miscompares++; $display("FAIL max_r_lt_d: got r=%h expected below 80", remainder);
        end
    endtask

    task automatic test_negative_correction();
        run_div(8'h60, 8'hC1);
        vectors++;
        if (w_log[9] !== 10'h380) begin
            miscompares++; $display("FAIL negcorr_final_w: got %h expected 380", w_log[9]);
        end
        vectors++;
        if ({err, quotient, remainder} !== {1'b0, 8'h7F, 8'h41}) begin
            miscompares++; $display("FAIL negcorr_result: got err=%b q=%h r=%h expected 0 7f 41", err, quotient, remainder);
        end
    endtask

    task automatic test_operand_errors();
        logic [7:0] en[2] = '{8'hC5, 8'h10};
        logic [7:0] ed[2] = '{8'h9F, 8'h40};
        for (int i = 0; i < 2; i++) begin
            run_div(en[i], ed[i]);
            vectors++;
            if (lat !== 2) begin
                miscompares++; $display("FAIL operr%0d_latency: got edge %0d expected edge 2", i, lat);
            end
            vectors++;
            if (busy_log[1] !== 1'b1) begin
                miscompares++; $display("FAIL operr%0d_busy: got %b expected 1", i, busy_log[1]);
            end
            vectors++;
            if ({busy, err, quotient, remainder} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
                miscompares++; $display("FAIL operr%0d_result: got busy=%b err=%b q=%h r=%h expected 0 1 00 00",
                                        i, busy, err, quotient, remainder);
            end
            @(posedge clock); #1;
            vectors++;
            if (err !== 1'b1) begin
                miscompares++; $display("FAIL operr%0d_err_hold: got %b expected 1", i, err);
            end
        end
        run_div(8'h9F, 8'hC5);
        vectors++;
        if ({err, quotient, remainder} !== {1'b0, 8'hCE, 8'h7A}) begin
            miscompares++; $display("FAIL operr_clear: got err=%b q=%h r=%h expected 0 ce 7a", err, quotient, remainder);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        N = 8'h9F; D = 8'hC5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, done, err, quotient, remainder, w, q, fsm_state} !== 33'h0) begin
            miscompares++; $display("FAIL abort_outputs: got busy=%b done=%b err=%b q=%h r=%h w=%h dig=%b st=%0d expected all 0",
                                    busy, done, err, quotient, remainder, w, q, fsm_state);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (done) done_cnt++;
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++; $display("FAIL abort_no_done: got %0d done pulses expected 0", done_cnt);
        end
        run_div(8'h9F, 8'hC5);
        vectors++;
        if ({lat[7:0], quotient, remainder} !== {8'd11, 8'hCE, 8'h7A}) begin
            miscompares++; $display("FAIL abort_rerun: got lat=%0d q=%h r=%h expected 11 ce 7a", lat, quotient, remainder);
        end
    endtask

    task automatic test_busy_ignore();
        int done_cnt = 0;
        int edges = 1;
        N = 8'h9F; D = 8'hC5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        edges++;
        N = 8'h01; D = 8'h80; start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        edges += 2;
        start = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clock); #1;
            edges++;
        end
        vectors++;
        if ({edges[7:0], quotient, remainder} !== {8'd11, 8'hCE, 8'h7A}) begin
            miscompares++; $display("FAIL busy_ignore_result: got edge=%0d q=%h r=%h expected 11 ce 7a",
                                    edges, quotient, remainder);
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (done) done_cnt++;
        end
        vectors++;
        if (done_cnt !== 0) begin
            miscompares++; $display("FAIL busy_ignore_extra_done: got %0d expected 0", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int done_at[4];
        int n_done = 0;
        int bad_q = 0;
        N = 8'h9F; D = 8'hC5; start = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clock); #1;
            if (done) begin
                if (n_done < 4) done_at[n_done] = e;
                n_done++;
                if ({quotient, remainder} !== 16'hCE7A) bad_q++;
            end
        end
        start = 1'b0;
        vectors++;
        if (n_done !== 3) begin
            miscompares++; $display("FAIL b2b_count: got %0d done pulses expected 3", n_done);
        end else begin
            vectors++;
            if (done_at[0] !== 11) begin
                miscompares++; $display("FAIL b2b_first: got edge %0d expected 11", done_at[0]);
            end
            vectors++;
            if ((done_at[1] - done_at[0]) !== 11 || (done_at[2] - done_at[1]) !== 11) begin
                miscompares++; $display("FAIL b2b_period: got %0d,%0d expected 11,11",
                                        done_at[1] - done_at[0], done_at[2] - done_at[1]);
            end
        end
        vectors++;
        if (bad_q !== 0) begin
            miscompares++; $display("FAIL b2b_results: got %0d wrong results expected 0", bad_q);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic test_random_identity();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            logic [7:0] n;
            logic [15:0] rhs;
            d = 8'($urandom_range(128, 255));
            n = 8'($urandom_range(0, int'(d) - 1));
            run_div(n, d);
            rhs = 16'(quotient) * 16'(d) + 16'(remainder);
            vectors++;
            if (rhs !== {n, 8'h00} || !(remainder < d) || err !== 1'b0) begin
                miscompares++; $display("FAIL rand8_%0d: n=%h d=%h got q=%h r=%h err=%b, q*d+r=%h expected %h with r<d",
                                        i, n, d, quotient, remainder, err, rhs, {n, 8'h00});
            end
        end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] d;
            logic [15:0] n;
            logic [31:0] rhs;
            int cnt;
            d = 16'($urandom_range(32768, 65535));
            n = 16'($urandom_range(0, int'(d) - 1));
            n16 = n; d16 = d; start16 = 1'b1;
            @(posedge clock); #1;
            start16 = 1'b0;
            cnt = 1;
            while (!done16 && cnt < 60) begin
                @(posedge clock); #1;
                cnt++;
            end
            rhs = 32'(quotient16) * 32'(d) + 32'(remainder16);
            vectors++;
            if (cnt !== 19) begin
                miscompares++; $display("FAIL rand16_%0d_latency: got edge %0d expected edge 19", i, cnt);
            end
            vectors++;
            if (rhs !== {n, 16'h0000} || !(remainder16 < d) || err16 !== 1'b0) begin
                miscompares++; $display("FAIL rand16_%0d: n=%h d=%h got q=%h r=%h err=%b, q*d+r=%h expected %h with r<d",
                                        i, n, d, quotient16, remainder16, err16, rhs, {n, 16'h0000});
            end
        end
    endtask

    initial begin
        test_reset();
        test_main_trace();
        test_zero_dividend();
        test_max_quotient();
        test_negative_correction();
        test_operand_errors();
        test_reset_abort();
        test_busy_ignore();
        test_back_to_back();
        test_random_identity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
